// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the multi-channel switch debouncer.
package debounce_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    PRESS    = 3'b001,
    HOLD_DLY = 3'b011,
    PRESSED  = 3'b010,
    REL      = 3'b110,
    REL_DLY  = 3'b111
  } state_e;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_DELAY_CYCLES = 500000;    // 10 ms @ 50 MHz
  localparam int unsigned DEF_LONG_CYCLES  = 50000000;  // 1 s @ 50 MHz

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, press/release FSM with hold-off counter.
// Optional long-press detector enabled by DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int unsigned LONG_CYCLES  = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic press_pulse,
  output logic release_pulse,
  output logic level,
  output logic busy,
  output logic long_press
);

  localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          sw_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dly_done;

  assign sw_s     = sync_q[1];
  assign dly_done = (cnt_q == CW'(DELAY_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], sw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs inside a hold-off window and is zero everywhere else.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    case (state_q)
      IDLE:     state_d = sw_s ? PRESS : IDLE;
      PRESS:    state_d = HOLD_DLY;
      HOLD_DLY: begin
        if (dly_done) state_d = PRESSED;
        else begin
          state_d = HOLD_DLY;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PRESSED:  state_d = sw_s ? PRESSED : REL;
      REL:      state_d = REL_DLY;
      REL_DLY: begin
        if (dly_done) state_d = IDLE;
        else begin
          state_d = REL_DLY;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  assign press_pulse   = (state_q == PRESS);
  assign release_pulse = (state_q == REL);
  assign level         = (state_q == PRESS) || (state_q == HOLD_DLY) || (state_q == PRESSED);
  assign busy          = (state_q == HOLD_DLY) || (state_q == REL_DLY);

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  logic [LW-1:0] lcnt_q;

  // Saturating at LONG_CYCLES makes the pulse fire once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            lcnt_q <= '0;
    else if (state_q != PRESSED)         lcnt_q <= '0;
    else if (lcnt_q != LW'(LONG_CYCLES)) lcnt_q <= lcnt_q + LW'(1);
  end

  assign long_press = (state_q == PRESSED) && (lcnt_q == LW'(LONG_CYCLES - 1));
`else
  // Constant 0; the parameter term only keeps LONG_CYCLES referenced.
  assign long_press = 1'b0 & (LONG_CYCLES > 0);
`endif

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent switch debouncers with press/release pulses and clean level.
// Long-press detection is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int unsigned LONG_CYCLES  = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] long_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .sw            (sw[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .level         (level[i]),
      .busy          (busy[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed, table-driven bench for debounce_multi (N_CH=2, DELAY_CYCLES=4, LONG_CYCLES=8).
module tb_debounce_multi;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [1:0] L0 = 2'b01;
  localparam logic [1:0] L1 = 2'b10;
`else
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw  = 2'b00;
  logic [1:0] press_pulse, release_pulse, level, busy, long_press;
  wire  [9:0] obs = {press_pulse, release_pulse, level, busy, long_press};

  debounce_multi #(
    .N_CH         (2),
    .DELAY_CYCLES (4),
    .LONG_CYCLES  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .level         (level),
    .busy          (busy),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  // One row = sw value held for n cycles, with the outputs expected after each of those edges.
  typedef struct packed {
    logic [1:0] sw;
    logic [7:0] n;
    logic [1:0] pr, rl, lv, bz, lg;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic [1:0] s, input int n, input logic [1:0] pr, input logic [1:0] rl,
                     input logic [1:0] lv, input logic [1:0] bz, input logic [1:0] lg);
    vec_t v;
    v.sw = s; v.n = 8'(n); v.pr = pr; v.rl = rl; v.lv = lv; v.bz = bz; v.lg = lg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [9:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s[%0d]: got pr_rl_lv_bz_lg=%b expected %b", nm, idx, obs, exp);
  endtask

  initial begin
    // Reset held with both switches high: everything stays 0.
    sw = 2'b11;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", 0, '0);

    // Switches held through deassertion are re-accepted 3 edges later.
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1 chk("reset_release", e, (e == 3) ? 10'b11_00_11_00_00 :
                                 (e == 4) ? 10'b00_00_11_11_00 : 10'b0);
    end

    // Asynchronous reset in the middle of the hold-off window.
    #2 rst = 1'b0;
    sw = 2'b00;
    #1 chk("async_reset", 0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 chk("post_reset", c, '0);
    end

    // Clean press on ch0, held 30 cycles.
    add(2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b01,  4, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b01,  7, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b00, L0);
    add(2'b01, 15, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Bounce on ch0 inside the press hold-off window.
    add(2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b01,  5, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // One-cycle press on ch0, then re-press during the release hold-off.
    add(2'b01,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00,  1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  4, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01,  4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b01,  4, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Long press on ch1, held 20 cycles.
    add(2'b10,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b10,  1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b10,  4, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00);
    add(2'b10,  7, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b10,  1, 2'b00, 2'b00, 2'b10, 2'b00, L1);
    add(2'b10,  5, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int c = 0; c < int'(tbl[r].n); c++) begin
        sw = tbl[r].sw;
        @(posedge clk);
        #1 chk("vec", r, {tbl[r].pr, tbl[r].rl, tbl[r].lv, tbl[r].bz, tbl[r].lg});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
